// File: rtl/control_sequencer.sv
// ============================================================================
// Module   : control_sequencer
// Purpose  : Top-level FETCH/EXECUTE/HALT sequencer of the control unit, with
//            branch resolution, NZCV flags, stall freeze and cycle watchdog.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_sequencer #(
    parameter int          MAX_EXEC_CYCLES = 4,
    parameter logic [31:0] HALT_WORD       = 32'hD440_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] instruction_in,
    input  logic [4:0]  status_in,
    input  logic [32:0] decoded_controlword,
    input  logic [63:0] decoded_constant,
    output logic [31:0] instruction,
    output logic [1:0]  state,
    output logic [32:0] controlword,
    output logic [63:0] constant,
    output logic [3:0]  flags,
    output logic        halted,
    output logic        fault
);

    localparam logic [1:0]  PH_FETCH   = 2'd0;
    localparam logic [1:0]  PH_EXEC    = 2'd1;
    localparam logic [1:0]  PH_HALT    = 2'd2;
    localparam logic [32:0] C_FETCH_CW = 33'h0_0000_0100;
    localparam logic [3:0]  C_MAX      = 4'(MAX_EXEC_CYCLES);

    logic [1:0]  r_phase;
    logic [31:0] r_ir;
    logic [1:0]  r_state;
    logic [3:0]  r_flags;
    logic [2:0]  r_wdog;
    logic        r_fault;

    logic [1:0]  w_phase_nxt;
    logic [31:0] w_ir_nxt;
    logic [1:0]  w_state_nxt;
    logic [3:0]  w_flags_nxt;
    logic [2:0]  w_wdog_nxt;
    logic        w_fault_nxt;
    logic [32:0] w_cw;
    logic [32:0] w_exec_cw;
    logic [63:0] w_const;
    logic [3:0]  w_wdog_inc;
    logic        w_is_cbz;
    logic        w_is_cbnz;
    logic        w_is_bcond;
    logic        w_cond;
    logic        w_taken;
    logic        w_v;
    logic        w_c;
    logic        w_n;
    logic        w_z;

    assign w_v = r_flags[3];
    assign w_c = r_flags[2];
    assign w_n = r_flags[1];
    assign w_z = r_flags[0];

    assign w_is_cbz   = (r_ir[30:24] == 7'b0110100);
    assign w_is_cbnz  = (r_ir[30:24] == 7'b0110101);
    assign w_is_bcond = (r_ir[31:24] == 8'b01010100);

    // ARM condition-code table on the registered flags
    always_comb begin
        w_cond = 1'b1;
        case (r_ir[3:0])
            4'b0000: w_cond = w_z;
            4'b0001: w_cond = ~w_z;
            4'b0010: w_cond = w_c;
            4'b0011: w_cond = ~w_c;
            4'b0100: w_cond = w_n;
            4'b0101: w_cond = ~w_n;
            4'b0110: w_cond = w_v;
            4'b0111: w_cond = ~w_v;
            4'b1000: w_cond = w_c & ~w_z;
            4'b1001: w_cond = ~(w_c & ~w_z);
            4'b1010: w_cond = (w_n == w_v);
            4'b1011: w_cond = (w_n != w_v);
            4'b1100: w_cond = ~w_z & (w_n == w_v);
            4'b1101: w_cond = ~(~w_z & (w_n == w_v));
            default: w_cond = 1'b1;
        endcase
    end

    // ZR comes straight from the ALU so CBZ/CBNZ resolve in the same cycle
    always_comb begin
        w_taken = 1'b1;
        if (w_is_cbz) begin
            w_taken = status_in[0];
        end else if (w_is_cbnz) begin
            w_taken = ~status_in[0];
        end else if (w_is_bcond) begin
            w_taken = w_cond;
        end
        w_exec_cw = decoded_controlword;
        if (!w_taken) begin
            w_exec_cw[5:4] = 2'b01;
            w_exec_cw[3]   = 1'b0;
        end
    end

    assign w_wdog_inc = {1'b0, r_wdog} + 4'd1;

    always_comb begin
        w_phase_nxt = r_phase;
        w_ir_nxt    = r_ir;
        w_state_nxt = r_state;
        w_flags_nxt = r_flags;
        w_wdog_nxt  = r_wdog;
        w_fault_nxt = r_fault;
        w_cw        = '0;
        w_const     = '0;
        case (r_phase)
            PH_FETCH: begin
                if (!stall) begin
                    w_cw        = C_FETCH_CW;
                    w_ir_nxt    = instruction_in;
                    w_state_nxt = 2'b00;
                    w_wdog_nxt  = 3'd0;
                    w_phase_nxt = PH_EXEC;
                end
            end
            PH_EXEC: begin
                if (r_ir == HALT_WORD) begin
                    if (!stall) begin
                        w_phase_nxt = PH_HALT;
                    end
                end else begin
                    w_const = decoded_constant;
                    if (!stall) begin
                        w_cw = w_exec_cw;
                        if (decoded_controlword[1:0] == 2'b00) begin
                            w_phase_nxt = PH_FETCH;
                        end else begin
                            w_state_nxt = decoded_controlword[1:0];
                            w_wdog_nxt  = w_wdog_inc[2:0];
                            if (w_wdog_inc == C_MAX) begin
                                w_fault_nxt = 1'b1;
                                w_phase_nxt = PH_HALT;
                            end
                        end
                    end
                end
            end
            PH_HALT: begin
                w_cw = '0;
            end
            default: begin
                w_phase_nxt = PH_FETCH;
            end
        endcase
        // stall already zeroes w_cw, so a stalled status_load never lands
        if (w_cw[2]) begin
            w_flags_nxt = status_in[4:1];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_phase <= PH_FETCH;
            r_ir    <= '0;
            r_state <= 2'b00;
            r_flags <= 4'b0000;
            r_wdog  <= 3'd0;
            r_fault <= 1'b0;
        end else begin
            r_phase <= w_phase_nxt;
            r_ir    <= w_ir_nxt;
            r_state <= w_state_nxt;
            r_flags <= w_flags_nxt;
            r_wdog  <= w_wdog_nxt;
            r_fault <= w_fault_nxt;
        end
    end

    assign instruction = r_ir;
    assign state       = r_state;
    assign controlword = w_cw;
    assign constant    = w_const;
    assign flags       = r_flags;
    assign halted      = (r_phase == PH_HALT);
    assign fault       = r_fault;

endmodule

`default_nettype wire

// File: tb/tb_control_sequencer.sv
// ============================================================================
// Module   : tb_control_sequencer
// Purpose  : Self-checking bench for control_sequencer: directed scenarios plus
//            randomized instruction streams against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_control_sequencer;

    localparam logic [32:0] C_FETCH_CW = 33'h0_0000_0100;
    localparam logic [31:0] C_HALT     = 32'hD440_0000;
    localparam logic [31:0] C_PLAIN    = 32'h8B00_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] instruction_in = '0;
    logic [4:0]  status_in = '0;
    logic [32:0] decoded_controlword = '0;
    logic [63:0] decoded_constant = '0;
    wire  [31:0] instruction;
    wire  [1:0]  state;
    wire  [32:0] controlword;
    wire  [63:0] constant;
    wire  [3:0]  flags;
    wire         halted;
    wire         fault;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [3:0]  m_flags = 4'b0000;
    logic [32:0] last_cw;
    logic [32:0] last_dec;

    control_sequencer #(
        .MAX_EXEC_CYCLES(4),
        .HALT_WORD      (C_HALT)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .stall              (stall),
        .instruction_in     (instruction_in),
        .status_in          (status_in),
        .decoded_controlword(decoded_controlword),
        .decoded_constant   (decoded_constant),
        .instruction        (instruction),
        .state              (state),
        .controlword        (controlword),
        .constant           (constant),
        .flags              (flags),
        .halted             (halted),
        .fault              (fault)
    );

    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    // ARM pseudocode form: base test on cond[3:1], inverted by cond[0]
    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic v, cc, n, z, r;
        v = f[3]; cc = f[2]; n = f[1]; z = f[0];
        case (c[3:1])
            3'd0: r = z;
            3'd1: r = cc;
            3'd2: r = n;
            3'd3: r = v;
            3'd4: r = cc && !z;
            3'd5: r = (n == v);
            3'd6: r = (n == v) && !z;
            default: r = 1'b1;
        endcase
        if (c[0] && c[3:1] != 3'd7) r = !r;
        return r;
    endfunction

    function automatic logic [32:0] ref_cw(input logic [31:0] ir, input logic [32:0] dec,
                                           input logic [3:0] f, input logic zr);
        logic taken;
        logic [32:0] r;
        taken = 1'b1;
        if (ir[30:24] == 7'h34)      taken = zr;
        else if (ir[30:24] == 7'h35) taken = !zr;
        else if (ir[31:24] == 8'h54) taken = ref_cond(ir[3:0], f);
        r = dec;
        if (!taken) r[5:3] = 3'b010;
        return r;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        stall = 1'b0;
        tick();
        reset = 1'b1;
        m_flags = 4'b0000;
    endtask

    // stall_at: -1 random stalls, -2 none, >=0 stall_len cycles at that step
    // sl_mode : 0 random status_load, 1 forced 1, 2 forced 0; st_force>=32 -> random status
    task automatic run_instr(input logic [31:0] ir, input int nsteps, input int stall_at,
                             input int stall_len, input int sl_mode, input int st_force);
        logic [63:0] rr;
        logic [32:0] dec, exp;
        logic [63:0] k;
        logic [4:0]  st;
        logic [1:0]  exp_state, ns;
        int          nst;
        nst = (stall_at == -1) ? int'($urandom_range(0, 1)) : 0;
        repeat (nst) begin
            stall = 1'b1;
            instruction_in = $urandom;
            #1;
            n_cmp++;
            if (controlword !== 33'd0) begin
                n_bad++;
                $display("FAIL fetch_stall_cw: got %h want %h", controlword, 33'd0);
            end
            tick();
        end
        stall = 1'b0;
        instruction_in = ir;
        #1;
        n_cmp++;
        if (controlword !== C_FETCH_CW || constant !== 64'd0) begin
            n_bad++;
            $display("FAIL fetch_cw: got %h/%h want %h/0", controlword, constant, C_FETCH_CW);
        end
        tick();
        n_cmp++;
        if (instruction !== ir) begin
            n_bad++;
            $display("FAIL ir_load: got %h want %h", instruction, ir);
        end
        exp_state = 2'b00;
        for (int s = 0; s < nsteps; s++) begin
            ns = (s == nsteps - 1) ? 2'b00 : 2'(s + 1);
            rr = {$urandom, $urandom};
            dec = rr[32:0];
            dec[5:3] = 3'b111;
            dec[1:0] = ns;
            if (sl_mode == 1) dec[2] = 1'b1;
            if (sl_mode == 2) dec[2] = 1'b0;
            k = {$urandom, $urandom};
            st = (st_force < 32) ? 5'(st_force) : 5'($urandom_range(0, 31));
            decoded_controlword = dec;
            decoded_constant = k;
            status_in = st;
            if (stall_at == s) nst = stall_len;
            else if (stall_at == -1) nst = ($urandom_range(0, 3) == 0) ? 1 : 0;
            else nst = 0;
            repeat (nst) begin
                stall = 1'b1;
                #1;
                n_cmp++;
                if (controlword !== 33'd0 || constant !== k || state !== exp_state) begin
                    n_bad++;
                    $display("FAIL exec_stall: cw %h const %h state %b want 0/%h/%b",
                             controlword, constant, state, k, exp_state);
                end
                tick();
                n_cmp++;
                if (flags !== m_flags) begin
                    n_bad++;
                    $display("FAIL stall_flags: got %b want %b", flags, m_flags);
                end
            end
            stall = 1'b0;
            #1;
            exp = ref_cw(ir, dec, m_flags, st[0]);
            n_cmp++;
            if (controlword !== exp || constant !== k || state !== exp_state) begin
                n_bad++;
                $display("FAIL exec_cw: cw %h const %h state %b want %h/%h/%b",
                         controlword, constant, state, exp, k, exp_state);
            end
            last_cw = controlword;
            last_dec = dec;
            tick();
            if (exp[2]) m_flags = st[4:1];
            n_cmp++;
            if (flags !== m_flags) begin
                n_bad++;
                $display("FAIL flags_update: got %b want %b", flags, m_flags);
            end
            exp_state = ns;
        end
        n_cmp++;
        if (halted !== 1'b0 || fault !== 1'b0) begin
            n_bad++;
            $display("FAIL no_halt: halted %b fault %b want 0/0", halted, fault);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #3;
        n_cmp++;
        if (controlword !== C_FETCH_CW || constant !== 64'd0 || instruction !== 32'd0 ||
            state !== 2'b00 || flags !== 4'd0 || halted !== 1'b0 || fault !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state: cw %h const %h ir %h st %b fl %b h %b f %b want fetch/zeros",
                     controlword, constant, instruction, state, flags, halted, fault);
        end
        do_reset();
    endtask

    task automatic test_cbz();
        run_instr(32'hB400_0040, 1, -2, 0, 2, 5'b00001);
        n_cmp++;
        if (last_cw[5:3] !== 3'b111 || last_cw !== last_dec) begin
            n_bad++;
            $display("FAIL cbz_taken: got %h want %h", last_cw, last_dec);
        end
        run_instr(32'hB400_0040, 1, -2, 0, 2, 5'b00000);
        n_cmp++;
        if (last_cw[5:3] !== 3'b010 || last_cw[32:6] !== last_dec[32:6] ||
            last_cw[2:0] !== last_dec[2:0]) begin
            n_bad++;
            $display("FAIL cbz_not_taken: got %h dec %h", last_cw, last_dec);
        end
    endtask

    task automatic test_bcond();
        run_instr(C_PLAIN, 1, -2, 0, 1, 5'b00010);
        n_cmp++;
        if (flags !== 4'b0001) begin
            n_bad++;
            $display("FAIL beq_flags_set: got %b want 0001", flags);
        end
        run_instr(32'h5400_0040, 1, -2, 0, 2, 32);
        n_cmp++;
        if (last_cw[5:3] !== 3'b111) begin
            n_bad++;
            $display("FAIL beq_taken: pc bits %b want 111", last_cw[5:3]);
        end
        run_instr(C_PLAIN, 1, -2, 0, 1, 5'b00000);
        run_instr(32'h5400_0040, 1, -2, 0, 2, 32);
        n_cmp++;
        if (flags !== 4'b0000 || last_cw[5:3] !== 3'b010) begin
            n_bad++;
            $display("FAIL beq_not_taken: flags %b pc bits %b want 0000/010", flags, last_cw[5:3]);
        end
    endtask

    task automatic test_stall_chain();
        run_instr(C_PLAIN, 3, 1, 2, 0, 32);
        stall = 1'b0;
        #1;
        n_cmp++;
        if (controlword !== C_FETCH_CW) begin
            n_bad++;
            $display("FAIL chain_back_to_fetch: got %h want %h", controlword, C_FETCH_CW);
        end
    endtask

    task automatic test_watchdog();
        logic [63:0] rr;
        logic [32:0] dec;
        stall = 1'b0;
        instruction_in = C_PLAIN;
        tick();
        for (int i = 0; i < 4; i++) begin
            rr = {$urandom, $urandom};
            dec = rr[32:0];
            dec[1:0] = 2'b01;
            decoded_controlword = dec;
            #1;
            n_cmp++;
            if (controlword !== dec || halted !== 1'b0 || fault !== 1'b0) begin
                n_bad++;
                $display("FAIL wdog_exec: cw %h h %b f %b want %h/0/0", controlword, halted, fault, dec);
            end
            tick();
            if (dec[2]) m_flags = status_in[4:1];
        end
        for (int i = 0; i < 3; i++) begin
            rr = {$urandom, $urandom};
            decoded_controlword = rr[32:0];
            #1;
            n_cmp++;
            if (fault !== 1'b1 || halted !== 1'b1 || controlword !== 33'd0) begin
                n_bad++;
                $display("FAIL wdog_fault: f %b h %b cw %h want 1/1/0", fault, halted, controlword);
            end
            tick();
        end
        do_reset();
        n_cmp++;
        if (fault !== 1'b0 || halted !== 1'b0) begin
            n_bad++;
            $display("FAIL wdog_clear: f %b h %b want 0/0", fault, halted);
        end
    endtask

    task automatic test_halt();
        run_instr(C_PLAIN, 1, -2, 0, 1, 5'b11110);
        stall = 1'b0;
        instruction_in = C_HALT;
        tick();
        decoded_controlword = 33'h1_FFFF_FFFE;
        #1;
        n_cmp++;
        if (controlword !== 33'd0 || halted !== 1'b0) begin
            n_bad++;
            $display("FAIL halt_exec: cw %h h %b want 0/0", controlword, halted);
        end
        tick();
        n_cmp++;
        if (halted !== 1'b1 || fault !== 1'b0 || controlword !== 33'd0 || flags !== 4'b1111) begin
            n_bad++;
            $display("FAIL halt_state: h %b f %b cw %h fl %b want 1/0/0/1111",
                     halted, fault, controlword, flags);
        end
        tick();
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (controlword !== C_FETCH_CW || constant !== 64'd0 || instruction !== 32'd0 ||
            state !== 2'b00 || flags !== 4'd0 || halted !== 1'b0 || fault !== 1'b0) begin
            n_bad++;
            $display("FAIL halt_async_reset: cw %h ir %h fl %b h %b want reset values",
                     controlword, instruction, flags, halted);
        end
        tick();
        reset = 1'b1;
        m_flags = 4'b0000;
    endtask

    task automatic test_random();
        logic [31:0] ir;
        int          kind;
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 3);
            ir = $urandom;
            if (kind == 0) ir[30:24] = 7'h34;
            if (kind == 1) ir[30:24] = 7'h35;
            if (kind == 2) ir[31:24] = 8'h54;
            if (ir == C_HALT) ir = C_PLAIN;
            run_instr(ir, $urandom_range(1, 3), -1, 0, 0, 32);
        end
    endtask

    initial begin
        test_reset();
        test_cbz();
        test_bcond();
        test_stall_chain();
        test_random();
        test_watchdog();
        test_halt();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/control_sequencer.md
# control_sequencer

Top-level sequencing FSM of the control unit. It fetches the instruction into a local instruction register and drives the decoder tree with `instruction` and `state`. It forwards the selected decoder's 33-bit control word to the datapath, resolving CBZ/CBNZ and B.cond taken/not-taken. It also owns the NZCV flag register, stall handling, HALT detection and a per-instruction cycle watchdog.

## Interface
- `MAX_EXEC_CYCLES`, 4: execute cycles allowed per instruction before fault (1..7).
- `HALT_WORD`, 32'hD440_0000: instruction encoding that stops the sequencer.

Ports:
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `stall`  in  1  freeze request from memory/bus.
- `instruction_in`  in  32  data bus value during FETCH.
- `status_in`  in  5  {V,C,N,Z,ZR} from ALU; ZR = current ALU result zero, combinational.
- `decoded_controlword`  in  33  control word from the decoder tree for (`instruction`, `state`).
- `decoded_constant`  in  64  constant from the decoder tree.
- `instruction`  out  32  instruction register.
- `state`  out  2  decoder micro-state.
- `controlword`  out  33  to datapath.
- `constant`  out  64  to datapath.
- `flags`  out  4  registered {V,C,N,Z}.
- `halted`  out  1  sticky stop.
- `fault`  out  1  sticky watchdog fault.

Control word layout, MSB first:
- alu_db_en[32], alu_b_sel[31], alu_fs[30:26], rf_b_db_en[25], sa[24:20], sb[19:15], da[14:10]
- rf_write[9], ram_db_en[8], ram_write[7], pc_db_en[6], pc_fs[5:4], pc_in_sel[3], status_load[2], next_state[1:0]

PC function codes: 00 hold, 01 +4, 10 load, 11 add constant·4.

## Operation

Phases: FETCH, EXECUTE, HALT.

FETCH:
- `controlword` = FETCH_CW: only ram_db_en=1, all other fields 0.
- `constant` = 0.
- If `stall`=0: IR ← `instruction_in`, state ← 00, watchdog ← 0, next phase EXECUTE.

EXECUTE:
- If IR == HALT_WORD: `controlword` = 0; next phase HALT.
- Otherwise `controlword` = `decoded_controlword`, `constant` = `decoded_constant`, with the branch override below.
- Branch override: CBZ is IR[30:24]=0110100; CBNZ is 0110101; B.cond is IR[31:24]=01010100.
  - CBZ taken iff ZR=1; CBNZ taken iff ZR=0.
  - B.cond condition IR[3:0] is evaluated against `flags` using the ARM table; 1110/1111 are always taken.
  - Not taken: pc_fs forced to 01 and pc_in_sel to 0; all other bits pass unchanged.
- Sequencing when `stall`=0:
  - next_state==00: next phase FETCH.
  - Otherwise state ← next_state, watchdog+1.
  - If watchdog+1 == MAX_EXEC_CYCLES with next_state≠00: fault ← 1, next phase HALT.
- Flags: if status_load=1 and `stall`=0, `flags` ← `status_in`[4:1] at the clock edge.

Stall:
- Any phase with `stall`=1: every register holds.
- `controlword` = 0 (no bus drivers, no writes, pc_fs=00). `constant` passes through.

HALT:
- `halted`=1, `controlword`=0.
- Exits only via reset.

## Timing
- Reset (async, `reset`=0):
  - phase FETCH, IR=0, state=00, flags=0, watchdog=0, `halted`=0, `fault`=0.
  - Consequently `controlword`=FETCH_CW and `constant`=0 while in reset.
- Fetch latency: 1 cycle. IR is valid the cycle after a non-stalled FETCH.
- Outputs are combinational from registers plus decoder inputs; `status_in` ZR affects `controlword` in the same cycle.
- A single-cycle instruction takes 2 cycles (FETCH + EXECUTE); an n-state instruction takes 1+n.
- Reset mid-instruction aborts immediately. No partial writes follow deassertion, because the first cycle is FETCH.
- `stall` and status_load in the same cycle: no flag update.
- Watchdog fault and HALT_WORD in the same cycle are impossible (HALT_WORD is checked first); `fault` stays 0.

## Test plan
- Reset then CBZ 0xB4000040 with ZR=1 → FETCH_CW for 1 cycle, then `controlword` = decoded word with pc_fs=11, pc_in_sel=1, next phase FETCH.
- Same CBZ with ZR=0 → pc_fs=01, pc_in_sel=0, all other bits identical to `decoded_controlword`.
- B.EQ (0x54000040):
  - after an instruction with status_load=1 and `status_in`=5'b00010 → `flags`=0001 and the branch is taken;
  - after `flags`=0000 → not taken.
- 3-state decoder chain (next_state 01→10→00) with `stall` held high for 2 cycles in state 01 → `controlword`=0 while stalled, state holds at 01, total 6 cycles from FETCH to next FETCH.
- Decoder returning next_state=01 forever with MAX_EXEC_CYCLES=4 → `fault`=1 and `halted`=1 after 4 execute cycles; `controlword`=0 thereafter until reset.
- Fetch 0xD4400000 → `halted`=1 the cycle after EXECUTE; assert `reset`=0 mid-HALT → all outputs return to reset values asynchronously.
